// File: rtl/rv2t_instruction_fetch.sv
// RV2T instruction fetch stage: owns the PC, reads instruction memory over a
// req/ack handshake and hands each word plus its address to decode.
module rv2t_instruction_fetch #(
    parameter int XLEN        = 32,
    parameter int PC_BITWIDTH = 24,
    parameter logic [PC_BITWIDTH-1:0] RESET_PC = '0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sync_reset,
    input  logic                   fetch_init,
    input  logic [PC_BITWIDTH-1:0] start_addr,
    input  logic                   fetch_enable,
    input  logic                   jump_active,
    input  logic [PC_BITWIDTH-1:0] jump_addr,
    output logic                   mem_read_en,
    output logic [PC_BITWIDTH-1:0] mem_read_addr,
    input  logic                   mem_read_ack,
    input  logic [XLEN-1:0]        mem_read_data,
    output logic                   enable_out,
    output logic [XLEN-1:0]        IR_out,
    output logic [PC_BITWIDTH-1:0] PC_out,
    output logic                   exception_instruction_addr_misaligned
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                 state;
    logic [PC_BITWIDTH-1:0] pc;
    logic                   discard;

    logic                   redirect;
    logic [PC_BITWIDTH-1:0] target;
    logic                   bad_jump;

    // fetch_init wins over jump_active and is never alignment-checked
    always_comb begin
        bad_jump = jump_active && !fetch_init && (jump_addr[1:0] != 2'b00);
        redirect = fetch_init || (jump_active && (jump_addr[1:0] == 2'b00));
        target   = fetch_init ? start_addr : jump_addr;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                                 <= S_IDLE;
            pc                                    <= RESET_PC;
            discard                               <= 1'b0;
            mem_read_en                           <= 1'b0;
            mem_read_addr                         <= '0;
            enable_out                            <= 1'b0;
            IR_out                                <= '0;
            PC_out                                <= '0;
            exception_instruction_addr_misaligned <= 1'b0;
        end else if (sync_reset) begin
            state                                 <= S_IDLE;
            pc                                    <= RESET_PC;
            discard                               <= 1'b0;
            mem_read_en                           <= 1'b0;
            mem_read_addr                         <= '0;
            enable_out                            <= 1'b0;
            IR_out                                <= '0;
            PC_out                                <= '0;
            exception_instruction_addr_misaligned <= 1'b0;
        end else begin
            mem_read_en                           <= 1'b0;
            enable_out                            <= 1'b0;
            exception_instruction_addr_misaligned <= bad_jump;
            case (state)
                S_IDLE: begin
                    if (fetch_enable) begin
                        mem_read_addr <= redirect ? target : pc;
                        pc            <= redirect ? target : pc;
                        mem_read_en   <= 1'b1;
                        state         <= S_WAIT;
                    end else if (redirect) begin
                        pc <= target;
                    end
                end
                S_WAIT: begin
                    if (mem_read_ack) begin
                        state   <= S_IDLE;
                        discard <= 1'b0;
                        // a redirect arriving with the ack makes this word stale too
                        if (redirect) begin
                            pc <= target;
                        end else if (!discard) begin
                            IR_out     <= mem_read_data;
                            PC_out     <= mem_read_addr;
                            enable_out <= 1'b1;
                            pc         <= pc + PC_BITWIDTH'(4);
                        end
                    end else if (redirect) begin
                        discard <= 1'b1;
                        pc      <= target;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv2t_instruction_fetch.sv
// Self-checking bench for rv2t_instruction_fetch: directed scenarios followed by
// random traffic, all compared against a transaction-level reference model.
module tb_rv2t_instruction_fetch;

    localparam int XLEN = 32;
    localparam int PCW  = 24;

    logic            clk;
    logic            reset_n;
    logic            sync_reset;
    logic            fetch_init;
    logic [PCW-1:0]  start_addr;
    logic            fetch_enable;
    logic            jump_active;
    logic [PCW-1:0]  jump_addr;
    logic            mem_read_en;
    logic [PCW-1:0]  mem_read_addr;
    logic            mem_read_ack;
    logic [XLEN-1:0] mem_read_data;
    logic            enable_out;
    logic [XLEN-1:0] IR_out;
    logic [PCW-1:0]  PC_out;
    logic            exception_instruction_addr_misaligned;

    int vectors    = 0;
    int miscompares = 0;

    // reference model state: next PC and the single outstanding read, if any
    int unsigned    m_pc;
    bit             m_pending;
    bit             m_stale;
    int unsigned    m_addr;
    int unsigned    m_ir;
    int unsigned    m_pcout;
    bit             m_rd;
    bit             m_en;
    bit             m_exc;

    rv2t_instruction_fetch #(.XLEN(XLEN), .PC_BITWIDTH(PCW), .RESET_PC('0)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .sync_reset(sync_reset),
        .fetch_init(fetch_init),
        .start_addr(start_addr),
        .fetch_enable(fetch_enable),
        .jump_active(jump_active),
        .jump_addr(jump_addr),
        .mem_read_en(mem_read_en),
        .mem_read_addr(mem_read_addr),
        .mem_read_ack(mem_read_ack),
        .mem_read_data(mem_read_data),
        .enable_out(enable_out),
        .IR_out(IR_out),
        .PC_out(PC_out),
        .exception_instruction_addr_misaligned(exception_instruction_addr_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_pending = 0; m_stale = 0; m_addr = 0;
        m_ir = 0; m_pcout = 0; m_rd = 0; m_en = 0; m_exc = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".mem_read_en"},   {31'b0, mem_read_en},  {31'b0, m_rd});
        check({tag, ".mem_read_addr"}, {8'b0, mem_read_addr}, m_addr);
        check({tag, ".enable_out"},    {31'b0, enable_out},   {31'b0, m_en});
        check({tag, ".IR_out"},        IR_out,                m_ir);
        check({tag, ".PC_out"},        {8'b0, PC_out},        m_pcout);
        check({tag, ".exception"},     {31'b0, exception_instruction_addr_misaligned}, {31'b0, m_exc});
    endtask

    // one clock with the given inputs; model advances, outputs checked after the edge
    task automatic step(input string tag, input bit fe, input bit ja, input int unsigned ja_addr,
                        input bit fi, input int unsigned sa, input bit ack,
                        input int unsigned data, input bit sr);
        bit          redir;
        int unsigned tgt;
        fetch_enable  = fe;
        jump_active   = ja;
        jump_addr     = PCW'(ja_addr);
        fetch_init    = fi;
        start_addr    = PCW'(sa);
        mem_read_ack  = ack;
        mem_read_data = data;
        sync_reset    = sr;
        @(posedge clk);
        if (sr) begin
            model_reset();
        end else begin
            ja_addr = ja_addr % (1 << PCW);
            sa      = sa % (1 << PCW);
            redir   = fi || (ja && (ja_addr % 4 == 0));
            tgt     = fi ? sa : ja_addr;
            m_exc   = ja && !fi && (ja_addr % 4 != 0);
            m_rd    = 0;
            m_en    = 0;
            if (!m_pending) begin
                if (fe) begin
                    if (redir) m_pc = tgt;
                    m_addr = m_pc; m_rd = 1; m_pending = 1; m_stale = 0;
                end else if (redir) begin
                    m_pc = tgt;
                end
            end else if (ack) begin
                if (!m_stale && !redir) begin
                    m_ir = data; m_pcout = m_addr; m_en = 1;
                    m_pc = (m_addr + 4) % (1 << PCW);
                end else if (redir) begin
                    m_pc = tgt;
                end
                m_pending = 0; m_stale = 0;
            end else if (redir) begin
                m_stale = 1; m_pc = tgt;
            end
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset_n = 1'b0; sync_reset = 0; fetch_init = 0; start_addr = '0;
        fetch_enable = 0; jump_active = 0; jump_addr = '0;
        mem_read_ack = 0; mem_read_data = '0;
        model_reset();
        #12;
        check_all("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;

        // basic fetch, two-cycle memory
        step("t1.req", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t1.addr0", {8'b0, mem_read_addr}, 32'h0);
        idle("t1.wait");
        step("t1.ack", 0, 0, 0, 0, 0, 1, 32'h13, 0);
        check("t1.ir", IR_out, 32'h13);
        step("t1.req2", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t1.addr4", {8'b0, mem_read_addr}, 32'h4);
        step("t1.ack2", 0, 0, 0, 0, 0, 1, 32'hDEAD0001, 0);

        // jump while waiting discards the word in flight
        step("t2.req", 1, 0, 0, 0, 0, 0, 0, 0);
        step("t2.jump", 0, 1, 32'h100, 0, 0, 0, 0, 0);
        step("t2.ack", 0, 0, 0, 0, 0, 1, 32'hBAD, 0);
        check("t2.no_en", {31'b0, enable_out}, 32'h0);
        step("t2.req2", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t2.addr100", {8'b0, mem_read_addr}, 32'h100);
        step("t2.ack2", 0, 0, 0, 0, 0, 1, 32'h00100093, 0);

        // misaligned target raises exception and leaves PC alone
        step("t3.jump", 0, 1, 32'h102, 0, 0, 0, 0, 0);
        check("t3.exc", {31'b0, exception_instruction_addr_misaligned}, 32'h1);
        idle("t3.exc_clear");
        step("t3.req", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t3.addr104", {8'b0, mem_read_addr}, 32'h104);
        step("t3.ack", 0, 0, 0, 0, 0, 1, 32'h11, 0);

        // fetch_init overrides a simultaneous jump
        step("t4.init", 0, 1, 32'h200, 1, 32'h80, 0, 0, 0);
        step("t4.req", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t4.addr80", {8'b0, mem_read_addr}, 32'h80);
        step("t4.ack", 0, 0, 0, 0, 0, 1, 32'h22, 0);

        // PC wraps at the top of the address space
        step("t5.jump", 0, 1, 32'hFFFFFC, 0, 0, 0, 0, 0);
        step("t5.req", 1, 0, 0, 0, 0, 0, 0, 0);
        step("t5.ack", 0, 0, 0, 0, 0, 1, 32'h33, 0);
        check("t5.pcout", {8'b0, PC_out}, 32'hFFFFFC);
        step("t5.req2", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t5.wrap", {8'b0, mem_read_addr}, 32'h0);
        step("t5.ack2", 0, 0, 0, 0, 0, 1, 32'h44, 0);

        // async reset during an outstanding read
        step("t6.req", 1, 0, 32'h0, 1, 32'h40, 0, 0, 0);
        idle("t6.wait");
        reset_n = 1'b0;
        #2;
        model_reset();
        check_all("t6.in_reset");
        #2;
        reset_n = 1'b1;
        step("t6.late_ack", 0, 0, 0, 0, 0, 1, 32'h55, 0);
        check("t6.no_en", {31'b0, enable_out}, 32'h0);
        step("t6.req2", 1, 0, 0, 0, 0, 0, 0, 0);
        check("t6.addr0", {8'b0, mem_read_addr}, 32'h0);
        step("t6.ack2", 0, 0, 0, 0, 0, 1, 32'h66, 0);

        // random traffic: aligned and misaligned jumps, inits, sync resets
        for (int i = 0; i < 600; i++) begin
            bit          fe, ja, fi, ack, sr;
            int unsigned ja_addr, sa;
            fe      = ($urandom_range(0, 2) == 0);
            ja      = ($urandom_range(0, 9) == 0);
            fi      = ($urandom_range(0, 24) == 0);
            ack     = ($urandom_range(0, 2) == 0);
            sr      = ($urandom_range(0, 79) == 0);
            ja_addr = $urandom_range(0, 32'hFFFFFF);
            if ($urandom_range(0, 3) != 0) ja_addr = ja_addr & 32'hFFFFFC;
            sa      = $urandom_range(0, 32'hFFFFFF) & 32'hFFFFFC;
            step("rand", fe, ja, ja_addr, fi, sa, ack, $urandom, sr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
